fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for a 16-bit pipeline.
// - Keeps the program counter and issues one instruction-memory read at a
//   time. A read may finish in the cycle it is issued, or several cycles later.
// - Sends the returned word straight to the IF/ID register in the cycle it
//   arrives.
// - If decode is stalling when the word arrives, the word is parked in a
//   one-entry hold buffer and presented when the stall clears.
// - A downstream redirect (taken branch/jump) flushes everything in flight.
// - A fetched word with opcode 5'b00000 halts fetching until the next redirect.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   NOP_INSTR    word driven on I_mem_out whenever fetch_valid is low
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   stall        decode hazard hold; nothing is presented while high
//   redirect     taken branch/jump resolved downstream
//   redirect_pc  redirect target (bit 0 ignored)
//   imem_req     instruction memory read request
//   imem_addr    instruction memory address
//   imem_data    instruction word, meaningful only with imem_done
//   imem_done    the outstanding read completes this cycle
//   I_mem_out    instruction presented to IF/ID
//   PC_2         address of the presented instruction + 2
//   fetch_valid  I_mem_out carries a real instruction this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] I_mem_out,
    output logic [15:0] PC_2,
    output logic        fetch_valid
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    // Architectural state
    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;        // address of the access currently in flight
    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pc2;
    logic        r_buf_valid;
    logic        r_kill;        // in-flight access belongs to a flushed path

    // Next-state values
    logic [1:0]  w_state_next;
    logic [15:0] w_pc_next;
    logic [15:0] w_addr_next;
    logic [15:0] w_buf_instr_next;
    logic [15:0] w_buf_pc2_next;
    logic        w_buf_valid_next;
    logic        w_kill_next;

    // Combinational helpers
    logic        w_in_run;
    logic        w_in_wait;
    logic        w_req;
    logic        w_done;
    logic [15:0] w_pc_plus2;
    logic        w_take_buf;
    logic        w_take_mem;
    logic        w_fetch_valid;
    logic [15:0] w_instr;
    logic [15:0] w_pc2;
    logic        w_is_halt;

    assign w_in_run  = (r_state == ST_RUN);
    assign w_in_wait = (r_state == ST_WAIT);

    // In RUN, a new read is issued only when there is nowhere else for the
    // word to go: the buffer is empty and decode is accepting.
    // Once in WAIT, the request is held until the memory answers, even across
    // a stall or a redirect. This keeps at most one access outstanding.
    assign w_req = !rst && ((w_in_run && !r_buf_valid && !stall) || w_in_wait);

    // A done pulse counts only while a request is actually being driven.
    // A late completion from an access abandoned by reset therefore falls on
    // a cycle with no request and is ignored.
    assign w_done = w_req && imem_done;

    assign w_pc_plus2 = r_pc + 16'd2;

    // Two possible sources for the presented instruction. They never coincide:
    // the buffer is only valid in RUN, and no request is issued while the
    // buffer is full.
    assign w_take_buf = w_in_run && r_buf_valid && !stall && !redirect;
    assign w_take_mem = w_done && !r_kill && !stall && !redirect;

    assign w_fetch_valid = !rst && (w_take_buf || w_take_mem);

    // While a non-killed access is pending, r_pc still equals the address of
    // that access. So r_pc + 2 is the correct PC_2 for a word arriving from
    // memory.
    assign w_instr = w_take_buf ? r_buf_instr : imem_data;
    assign w_pc2   = w_take_buf ? r_buf_pc2   : w_pc_plus2;

    assign w_is_halt = w_fetch_valid && (w_instr[15:11] == HALT_OPCODE);

    // Outputs
    assign imem_req    = w_req;
    // In WAIT, the address is taken from the register captured at issue time.
    // It therefore stays stable even after a redirect has moved r_pc.
    assign imem_addr   = w_in_wait ? r_addr : r_pc;
    assign fetch_valid = w_fetch_valid;
    assign I_mem_out   = w_fetch_valid ? w_instr : NOP_INSTR;
    assign PC_2        = w_pc2;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_addr_next      = r_addr;
        w_buf_instr_next = r_buf_instr;
        w_buf_pc2_next   = r_buf_pc2;
        w_buf_valid_next = r_buf_valid;
        w_kill_next      = r_kill;

        // Track the PC every cycle in RUN. Any access issued from RUN then
        // has its address latched for the WAIT cycles that follow.
        if (w_in_run) begin
            w_addr_next = r_pc;
        end

        if (redirect) begin
            // Redirect overrides everything but reset. The buffered word and
            // any word arriving this cycle belong to the wrong path.
            w_pc_next        = redirect_pc & 16'hFFFE;
            w_buf_valid_next = 1'b0;
            if (w_req && !imem_done) begin
                // An access is (or has just become) outstanding.
                // Wait it out, then throw its word away.
                w_state_next = ST_WAIT;
                w_kill_next  = 1'b1;
            end else begin
                // Nothing outstanding after this edge. This also covers
                // restarting from HALT.
                w_state_next = ST_RUN;
                w_kill_next  = 1'b0;
            end
        end else if (w_done) begin
            w_state_next = ST_RUN;
            w_kill_next  = 1'b0;
            if (!r_kill) begin
                w_pc_next = w_pc_plus2;
                if (stall) begin
                    w_buf_instr_next = imem_data;
                    w_buf_pc2_next   = w_pc_plus2;
                    w_buf_valid_next = 1'b1;
                end else if (w_is_halt) begin
                    w_state_next = ST_HALT;
                end
            end
            // A killed completion leaves r_pc alone: it already holds the
            // redirect target.
        end else if (w_req) begin
            // Issued (or still pending) without completion.
            w_state_next = ST_WAIT;
        end else if (w_take_buf) begin
            w_buf_valid_next = 1'b0;
            if (w_is_halt) begin
                w_state_next = ST_HALT;
            end
        end else if (r_state != ST_RUN && r_state != ST_WAIT && r_state != ST_HALT) begin
            // Recover from the unused encoding.
            w_state_next = ST_RUN;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc2   <= 16'h0000;
            r_buf_valid <= 1'b0;
            r_kill      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_addr      <= w_addr_next;
            r_buf_instr <= w_buf_instr_next;
            r_buf_pc2   <= w_buf_pc2_next;
            r_buf_valid <= w_buf_valid_next;
            r_kill      <= w_kill_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// The bench has three processes, each acting at a fixed point in the cycle:
// - Driver, at the falling edge: drives rst, stall and redirect.
// - Memory responder, 1 time unit later: models the instruction memory with a
//   variable access latency. It also keeps the program-order model: the next
//   expected fetch address, whether an access was overtaken by a redirect, and
//   a queue of words that must reach decode.
// - Monitor, 2 time units after the falling edge: pops that queue whenever
//   fetch_valid is seen.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_done;
    logic [15:0] I_mem_out;
    logic [15:0] PC_2;
    logic        fetch_valid;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_done   (imem_done),
        .I_mem_out   (I_mem_out),
        .PC_2        (PC_2),
        .fetch_valid (fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          presented = 0;
    logic [15:0] mem [0:32767];
    exp_t        exp_q[$];

    // Program-order reference state
    logic [15:0] model_pc;
    logic        halted;
    logic        in_flight;
    logic        killed;
    logic [15:0] cur_addr;
    int          lat;
    int          cnt;
    int          lat_mode;     // <0: random latency 0..3, else fixed

    task automatic chk(input string name, input logic ok,
                       input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // ---------------------------------------------------------------- memory
    initial begin
        imem_done = 1'b0;
        imem_data = 16'h0000;
        in_flight = 1'b0;
        killed    = 1'b0;
        model_pc  = RESET_PC;
        halted    = 1'b0;
        cur_addr  = 16'h0000;
        lat       = 0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            #1;
            imem_done = 1'b0;
            imem_data = 16'($urandom);
            if (rst) begin
                chk("rst_req", imem_req === 1'b0, 16'(imem_req), 16'h0);
                // Stray completions while in reset must be ignored.
                imem_done = 1'($urandom_range(0, 1));
                in_flight = 1'b0;
                killed    = 1'b0;
                exp_q.delete();
                model_pc  = RESET_PC;
                halted    = 1'b0;
            end else begin
                if (in_flight) begin
                    chk("hold_req", imem_req === 1'b1, 16'(imem_req), 16'h1);
                    chk("hold_addr", imem_addr === cur_addr, imem_addr, cur_addr);
                    if (imem_req !== 1'b1) begin
                        in_flight = 1'b0;
                    end
                end else begin
                    if (halted) begin
                        chk("halt_req", imem_req === 1'b0, 16'(imem_req), 16'h0);
                    end else if (exp_q.size() != 0) begin
                        chk("buf_req", imem_req === 1'b0, 16'(imem_req), 16'h0);
                    end else if (!stall) begin
                        chk("run_req", imem_req === 1'b1, 16'(imem_req), 16'h1);
                    end
                    if (imem_req === 1'b1) begin
                        chk("req_addr", imem_addr === model_pc, imem_addr, model_pc);
                        in_flight = 1'b1;
                        killed    = 1'b0;
                        cur_addr  = model_pc;
                        cnt       = 0;
                        lat       = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    end
                end
                if (in_flight) begin
                    if (cnt == lat) begin
                        exp_t e;
                        imem_done = 1'b1;
                        imem_data = mem[imem_addr[15:1]];
                        if (!redirect && !killed) begin
                            e.instr  = mem[cur_addr[15:1]];
                            e.pc2    = cur_addr + 16'd2;
                            exp_q.push_back(e);
                            model_pc = cur_addr + 16'd2;
                        end
                        in_flight = 1'b0;
                    end else begin
                        cnt++;
                    end
                end
                if (redirect) begin
                    if (in_flight) begin
                        killed = 1'b1;
                    end
                    exp_q.delete();
                    model_pc = redirect_pc & 16'hFFFE;
                    halted   = 1'b0;
                end
            end
        end
    end

    // --------------------------------------------------------------- monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                chk("rst_valid", fetch_valid === 1'b0, 16'(fetch_valid), 16'h0);
                chk("rst_nop", I_mem_out === NOP, I_mem_out, NOP);
            end else begin
                if (redirect) begin
                    chk("redirect_valid", fetch_valid === 1'b0, 16'(fetch_valid), 16'h0);
                end else if (stall) begin
                    chk("stall_valid", fetch_valid === 1'b0, 16'(fetch_valid), 16'h0);
                end else if (exp_q.size() != 0) begin
                    chk("present_valid", fetch_valid === 1'b1, 16'(fetch_valid), 16'h1);
                end else begin
                    chk("idle_valid", fetch_valid === 1'b0, 16'(fetch_valid), 16'h0);
                end
                if (fetch_valid === 1'b1) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("instr", I_mem_out === e.instr, I_mem_out, e.instr);
                        chk("pc2", PC_2 === e.pc2, PC_2, e.pc2);
                        presented++;
                        $display("TX t=%0t instr=%h pc2=%h", $time, I_mem_out, PC_2);
                        if (e.instr[15:11] == 5'b00000) begin
                            halted = 1'b1;
                        end
                    end
                end else begin
                    chk("nop", I_mem_out === NOP, I_mem_out, NOP);
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic step(input logic r, input logic s, input logic rd, input logic [15:0] tgt);
        @(negedge clk);
        rst         = r;
        stall       = r ? 1'b0 : s;
        redirect    = r ? 1'b0 : rd;
        redirect_pc = tgt;
    endtask

    // Run idle cycles until an access is pending with at least one more
    // cycle to go.
    task automatic wait_flight(input string name);
        int k;
        k = 0;
        while (!(in_flight && cnt < lat) && k < 20) begin
            step(1'b0, 1'b0, 1'b0, 16'h0);
            k++;
        end
        chk(name, in_flight && cnt < lat, 16'(in_flight), 16'h1);
    endtask

    initial begin
        logic [15:0] w;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        lat_mode    = 0;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b00000) begin
                w[15:11] = 5'b00001;
            end
            mem[i] = w;
        end
        mem[16'h0050 >> 1] = 16'h0000;

        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0);

        // Hit stream from reset: 0,2,4,... one per cycle
        lat_mode = 0;
        repeat (8) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Multi-cycle access at 0x0010 (three extra cycles)
        lat_mode = 3;
        repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Stall raised during WAIT, completion buffered, then released
        lat_mode = 2;
        wait_flight("flight_stall");
        repeat (4) step(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Redirect while in WAIT kills the in-flight word
        lat_mode = 3;
        wait_flight("flight_kill");
        step(1'b0, 1'b0, 1'b1, 16'h0101);
        lat_mode = 0;
        repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Halt at 0x0050, then restart at 0x0040
        step(1'b0, 1'b0, 1'b1, 16'h0048);
        repeat (12) step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("halted", halted === 1'b1, 16'(halted), 16'h1);
        step(1'b0, 1'b0, 1'b1, 16'h0040);
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Wrap-around past 0xFFFE
        step(1'b0, 1'b0, 1'b1, 16'hFFFC);
        repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Randomised traffic with sprinkled halt words
        for (int i = 0; i < 32768; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                w = 16'($urandom);
                w[15:11] = 5'b00000;
                mem[i] = w;
            end
        end
        lat_mode = -1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 999) < 4) begin
                step(1'b1, 1'b0, 1'b0, 16'h0);
                step(1'b1, 1'b0, 1'b0, 16'h0);
            end else begin
                step(1'b0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
                     16'($urandom));
            end
        end

        // Drain: nothing may be left owed to decode
        lat_mode = 0;
        repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0);
        chk("drain_empty", exp_q.size() == 0, 16'(exp_q.size()), 16'h0);
        chk("presented_some", presented > 100, 16'(presented), 16'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
